// File: rtl/reg_bus_sequencer.sv
// Round-robin sequencer for register-to-register moves on the shared internal bus.
// Optional immediate moves are enabled by defining XFER_IMM_EN.
module reg_bus_sequencer #(
  parameter int NREG   = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [IDX_W-1:0]  a_src,
  input  logic [IDX_W-1:0]  a_dst,
  input  logic              a_imm,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [IDX_W-1:0]  b_src,
  input  logic [IDX_W-1:0]  b_dst,
  input  logic              b_imm,
  input  logic [DATA_W-1:0] b_data,
  output logic [NREG-1:0]   en_o,
  output logic [NREG-1:0]   ld_o,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_drv_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              done_id_o,
  output logic              err_o
);

  // Handshake: a command transfers in a cycle where valid && ready; ready is
  // only raised in IDLE, and the command fields are ignored once accepted.
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

  state_t state, state_n;
  logic last_grant, last_grant_n;
  logic [IDX_W-1:0] cmd_src, cmd_src_n, cmd_dst, cmd_dst_n;
  logic cmd_imm, cmd_imm_n, cmd_id, cmd_id_n;
  logic [DATA_W-1:0] cmd_data, cmd_data_n;
  logic [NREG-1:0] en_n, ld_n;
  logic [DATA_W-1:0] bus_q, bus_n;
  logic drv_q, drv_n, busy_n, done_n, id_n, err_n;

  logic grant, gid, sel_imm, bad;
  logic [IDX_W-1:0] sel_src, sel_dst;
  logic [DATA_W-1:0] sel_data;
  logic a_imm_eff, b_imm_eff;
  logic [DATA_W-1:0] a_data_eff, b_data_eff;

  function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NREG'(1) << idx;
  endfunction

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cmd_src_n    = cmd_src;
    cmd_dst_n    = cmd_dst;
    cmd_imm_n    = cmd_imm;
    cmd_data_n   = cmd_data;
    cmd_id_n     = cmd_id;
    en_n         = '0;
    ld_n         = '0;
    bus_n        = '0;
    drv_n        = 1'b0;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;
    id_n         = done_id_o;
    grant        = 1'b0;
    gid          = 1'b0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    sel_src      = a_src;
    sel_dst      = a_dst;
    sel_imm      = a_imm_eff;
    sel_data     = a_data_eff;
    bad          = 1'b0;
    case (state)
      IDLE: begin
        // The requester that did not win last time gets priority on contention.
        if (a_valid && (!b_valid || last_grant)) begin
          grant = 1'b1;
          gid   = 1'b0;
        end else if (b_valid) begin
          grant = 1'b1;
          gid   = 1'b1;
        end
        a_ready = grant && !gid;
        b_ready = grant && gid;
        if (gid) begin
          sel_src  = b_src;
          sel_dst  = b_dst;
          sel_imm  = b_imm_eff;
          sel_data = b_data_eff;
        end
        if (sel_imm)
          bad = int'(sel_dst) >= NREG;
        else
          bad = (sel_src == sel_dst) || (int'(sel_src) >= NREG) || (int'(sel_dst) >= NREG);
        if (grant) begin
          last_grant_n = gid;
          cmd_src_n    = sel_src;
          cmd_dst_n    = sel_dst;
          cmd_imm_n    = sel_imm;
          cmd_data_n   = sel_data;
          cmd_id_n     = gid;
          if (bad) begin
            err_n = 1'b1;
            id_n  = gid;
          end else begin
            state_n = DRIVE;
            busy_n  = 1'b1;
            en_n    = sel_imm ? '0 : onehot(sel_src);
            drv_n   = sel_imm;
            bus_n   = sel_imm ? sel_data : '0;
          end
        end
      end
      DRIVE: begin
        state_n = LOAD;
        busy_n  = 1'b1;
        en_n    = cmd_imm ? '0 : onehot(cmd_src);
        ld_n    = onehot(cmd_dst);
        drv_n   = cmd_imm;
        bus_n   = cmd_imm ? cmd_data : '0;
      end
      LOAD: begin
        state_n = IDLE;
        done_n  = 1'b1;
        id_n    = cmd_id;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_src    <= '0;
      cmd_dst    <= '0;
      cmd_imm    <= 1'b0;
      cmd_data   <= '0;
      cmd_id     <= 1'b0;
      en_o       <= '0;
      ld_o       <= '0;
      bus_q      <= '0;
      drv_q      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      done_id_o  <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cmd_src    <= cmd_src_n;
      cmd_dst    <= cmd_dst_n;
      cmd_imm    <= cmd_imm_n;
      cmd_data   <= cmd_data_n;
      cmd_id     <= cmd_id_n;
      en_o       <= en_n;
      ld_o       <= ld_n;
      bus_q      <= bus_n;
      drv_q      <= drv_n;
      busy_o     <= busy_n;
      done_o     <= done_n;
      done_id_o  <= id_n;
      err_o      <= err_n;
    end
  end

`ifdef XFER_IMM_EN
  assign a_imm_eff  = a_imm;
  assign b_imm_eff  = b_imm;
  assign a_data_eff = a_data;
  assign b_data_eff = b_data;
  assign bus_o      = bus_q;
  assign bus_drv_o  = drv_q;
`else
  logic unused_imm;
  assign a_imm_eff  = 1'b0;
  assign b_imm_eff  = 1'b0;
  assign a_data_eff = '0;
  assign b_data_eff = '0;
  assign bus_o      = '0;
  assign bus_drv_o  = 1'b0;
  assign unused_imm = ^{a_imm, b_imm, a_data, b_data, bus_q, drv_q};
`endif

endmodule
